// File: rtl/ps2_hex_entry.sv
// PS/2 hex entry: turns a scancode byte stream into a multi-digit hex entry.
// Make/break/extended prefixes are tracked by a small FSM. Digits shift in at
// the low nibble. Backspace, Escape and Enter edit or commit the buffer.
module ps2_hex_entry #(
  parameter int          DIGITS     = 4,
  parameter logic [7:0]  ENTER_CODE = 8'h5A,
  parameter logic [7:0]  BKSP_CODE  = 8'h66,
  parameter logic [7:0]  ESC_CODE   = 8'h76,
  localparam int         W          = 4 * DIGITS,
  localparam int         CW         = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    keycode,
  input  logic          keycode_valid,
  output logic [W-1:0]  entry,
  output logic [CW-1:0] count,
  output logic [W-1:0]  value,
  output logic          value_valid,
  output logic          digit_strobe,
  output logic          overflow
);

  localparam logic [7:0] BREAK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX   = 8'hE0;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t state, state_next;

  // Actions decoded from the current byte in the current state
  logic act_digit, act_bksp, act_esc, act_enter;
  logic [3:0] nib;

  logic [W-1:0]  entry_next, value_next;
  logic [CW-1:0] count_next;
  logic          value_valid_next, digit_strobe_next, overflow_next;

  // Make code to hex nibble; bit 4 flags a hex key
  function automatic logic [4:0] hex_decode(input logic [7:0] code);
    case (code)
      8'h45: return 5'h10;
      8'h16: return 5'h11;
      8'h1E: return 5'h12;
      8'h26: return 5'h13;
      8'h25: return 5'h14;
      8'h2E: return 5'h15;
      8'h36: return 5'h16;
      8'h3D: return 5'h17;
      8'h3E: return 5'h18;
      8'h46: return 5'h19;
      8'h1C: return 5'h1A;
      8'h32: return 5'h1B;
      8'h21: return 5'h1C;
      8'h23: return 5'h1D;
      8'h24: return 5'h1E;
      8'h2B: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and action decode for each sampled byte
  always_comb begin
    logic [4:0] hd;
    hd         = hex_decode(keycode);
    nib        = hd[3:0];
    state_next = state;
    act_digit  = 1'b0;
    act_bksp   = 1'b0;
    act_esc    = 1'b0;
    act_enter  = 1'b0;
    if (keycode_valid) begin
      case (state)
        IDLE: begin
          if (keycode == BREAK_PFX)       state_next = BREAK;
          else if (keycode == EXT_PFX)    state_next = EXT;
          else if (hd[4])                 act_digit  = 1'b1;
          else if (keycode == BKSP_CODE)  act_bksp   = 1'b1;
          else if (keycode == ESC_CODE)   act_esc    = 1'b1;
          else if (keycode == ENTER_CODE) act_enter  = 1'b1;
        end
        BREAK: begin
          if (keycode != BREAK_PFX) state_next = IDLE;
        end
        EXT: begin
          if (keycode == BREAK_PFX) state_next = EXT_BREAK;
          else if (keycode != EXT_PFX) begin
            state_next = IDLE;
            act_enter  = (keycode == ENTER_CODE);
          end
        end
        EXT_BREAK: begin
          if (keycode != BREAK_PFX) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Buffer and pulse updates implied by the decoded action
  always_comb begin
    entry_next        = entry;
    count_next        = count;
    value_next        = value;
    value_valid_next  = 1'b0;
    digit_strobe_next = 1'b0;
    overflow_next     = 1'b0;
    if (act_digit) begin
      if (count < CW'(DIGITS)) begin
        entry_next        = {entry[W-5:0], nib};
        count_next        = count + CW'(1);
        digit_strobe_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end else if (act_bksp) begin
      if (count != '0) begin
        entry_next = entry >> 4;
        count_next = count - CW'(1);
      end
    end else if (act_esc) begin
      entry_next = '0;
      count_next = '0;
    end else if (act_enter) begin
      if (count != '0) begin
        value_next       = entry;
        value_valid_next = 1'b1;
        entry_next       = '0;
        count_next       = '0;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry        <= '0;
      count        <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      digit_strobe <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      entry        <= entry_next;
      count        <= count_next;
      value        <= value_next;
      value_valid  <= value_valid_next;
      digit_strobe <= digit_strobe_next;
      overflow     <= overflow_next;
    end
  end

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed bench for ps2_hex_entry with DIGITS=4.
module tb_ps2_hex_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic        keycode_valid = 1'b0;
  logic [15:0] entry;
  logic [2:0]  count;
  logic [15:0] value;
  logic        value_valid, digit_strobe, overflow;

  int checks = 0;
  int errors = 0;

  ps2_hex_entry #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .keycode(keycode), .keycode_valid(keycode_valid),
    .entry(entry), .count(count), .value(value), .value_valid(value_valid),
    .digit_strobe(digit_strobe), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One byte with a one-cycle strobe; returns at the negedge after the sampling edge
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    keycode       = c;
    keycode_valid = 1'b1;
    @(negedge clk);
    keycode_valid = 1'b0;
  endtask

  logic [7:0]  codes [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
  logic [15:0] steps [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};

  initial begin
    // Reset state
    #12;
    chk("rst_entry", entry, 0);
    chk("rst_count", count, 0);
    chk("rst_value", value, 0);
    chk("rst_pulses", {value_valid, digit_strobe, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Commit: make, break, then Enter
    for (int i = 0; i < 4; i++) begin
      send(codes[i]);
      chk("commit_entry", entry, steps[i]);
      chk("commit_strobe", digit_strobe, 1);
      send(8'hF0);
      chk("break_prefix_strobe", digit_strobe, 0);
      send(codes[i]);
      chk("break_entry", entry, steps[i]);
      chk("break_strobe", digit_strobe, 0);
    end
    chk("commit_count", count, 4);
    send(8'h5A);
    chk("commit_value", value, 16'h1234);
    chk("commit_vv", value_valid, 1);
    chk("commit_clear_entry", entry, 0);
    chk("commit_clear_count", count, 0);
    @(negedge clk);
    chk("commit_vv_once", value_valid, 0);

    // Overflow on fifth digit
    for (int i = 0; i < 4; i++) send(codes[i]);
    send(8'h2E);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_entry", entry, 16'h1234);
    chk("ovf_count", count, 4);
    chk("ovf_strobe", digit_strobe, 0);
    @(negedge clk);
    chk("ovf_once", overflow, 0);
    send(8'h76);
    chk("esc_entry", entry, 0);

    // Edit: digits, backspace, escape, backspace on empty
    send(8'h16); chk("edit1", entry, 16'h0001);
    send(8'h1E); chk("edit2", entry, 16'h0012);
    send(8'h66); chk("edit_bksp", entry, 16'h0001);
    chk("edit_bksp_count", count, 1);
    send(8'h1C); chk("edit_a", entry, 16'h001A);
    chk("edit_count", count, 2);
    send(8'h76);
    chk("edit_esc_entry", entry, 0);
    chk("edit_esc_count", count, 0);
    chk("edit_esc_value", value, 16'h1234);
    send(8'h66);
    chk("bksp_empty_entry", entry, 0);
    chk("bksp_empty_count", count, 0);

    // Prefixes: keypad Enter commits
    send(8'h1C); send(8'h32);
    chk("pfx_entry", entry, 16'h00AB);
    send(8'hE0); send(8'h5A);
    chk("kp_enter_value", value, 16'h00AB);
    chk("kp_enter_vv", value_valid, 1);
    // Keypad Enter release does nothing
    send(8'h1C); send(8'h32);
    send(8'hE0); send(8'hF0); send(8'h5A);
    chk("ext_break_vv", value_valid, 0);
    chk("ext_break_entry", entry, 16'h00AB);
    chk("ext_break_count", count, 2);
    // Extended code is never a digit
    send(8'hE0); send(8'h16);
    chk("ext_digit_entry", entry, 16'h00AB);
    chk("ext_digit_strobe", digit_strobe, 0);
    // Repeated F0 then release, then a fresh make
    send(8'hF0); send(8'hF0); send(8'h16);
    chk("ff_release_entry", entry, 16'h00AB);
    chk("ff_release_strobe", digit_strobe, 0);
    send(8'h16);
    chk("after_release_entry", entry, 16'h0AB1);
    chk("after_release_strobe", digit_strobe, 1);
    send(8'h76);

    // Empty Enter
    send(8'h5A);
    chk("empty_enter_vv", value_valid, 0);
    chk("empty_enter_value", value, 16'h00AB);

    // Asynchronous reset mid-sequence
    send(8'h16); send(8'h1E);
    chk("pre_rst_entry", entry, 16'h0012);
    send(8'hE0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_entry", entry, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_value", value, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h5A);
    chk("post_rst_vv", value_valid, 0);
    chk("post_rst_value", value, 0);
    send(8'h16);
    chk("post_rst_fresh_digit", entry, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
